// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// default latencies and the long-latency op predicate.
package mdu_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// res_valid is low for divide-by-zero so the sequencer can skip the write.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_valid
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] safe_b;
    logic [31:0] safe_abs_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic        b_zero;

    // Sign-extended 64x64 multiply keeps the low 64 bits correct for signed operands.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign b_zero     = (b == 32'd0);
    assign abs_a      = a[31] ? (32'd0 - a) : a;
    assign abs_b      = b[31] ? (32'd0 - b) : b;
    assign safe_b     = b_zero ? 32'd1 : b;
    assign safe_abs_b = b_zero ? 32'd1 : abs_b;

    // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly.
    assign uq     = a / safe_b;
    assign ur     = a % safe_b;
    assign sq_mag = abs_a / safe_abs_b;
    assign sr_mag = abs_a % safe_abs_b;

    always_comb begin
        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_valid = 1'b0;
        case (op)
            OP_MULT: begin
                res_hi    = prod_s[63:32];
                res_lo    = prod_s[31:0];
                res_valid = 1'b1;
            end
            OP_MULTU: begin
                res_hi    = prod_u[63:32];
                res_lo    = prod_u[31:0];
                res_valid = 1'b1;
            end
            OP_DIV: begin
                res_lo    = (a[31] ^ b[31]) ? (32'd0 - sq_mag) : sq_mag;
                res_hi    = a[31] ? (32'd0 - sr_mag) : sr_mag;
                res_valid = !b_zero;
            end
            OP_DIVU: begin
                res_lo    = uq;
                res_hi    = ur;
                res_valid = !b_zero;
            end
            default: begin
                res_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO register file with a fixed-latency busy window for mult/div.
// The result is computed at issue, held, and written when the countdown expires.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    mdu_state_e  state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0] res_hi_reg, res_hi_next;
    logic [31:0] res_lo_reg, res_lo_next;
    logic        res_valid_reg, res_valid_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    logic [31:0] arith_hi;
    logic [31:0] arith_lo;
    logic        arith_valid;

    mdu_arith u_arith (
        .op        (op),
        .a         (a),
        .b         (b),
        .res_hi    (arith_hi),
        .res_lo    (arith_lo),
        .res_valid (arith_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            res_hi_reg    <= 32'd0;
            res_lo_reg    <= 32'd0;
            res_valid_reg <= 1'b0;
            hi_reg        <= 32'd0;
            lo_reg        <= 32'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            res_hi_reg    <= res_hi_next;
            res_lo_reg    <= res_lo_next;
            res_valid_reg <= res_valid_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        res_hi_next    = res_hi_reg;
        res_lo_next    = res_lo_reg;
        res_valid_next = res_valid_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(op)) begin
                        res_hi_next    = arith_hi;
                        res_lo_next    = arith_lo;
                        res_valid_next = arith_valid;
                        cnt_next       = is_div_op(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_next     = ST_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_next = a;
                    end else if (op == OP_MTLO) begin
                        lo_next = a;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_reg == CW'(1)) begin
                    // Divide-by-zero leaves HI/LO untouched.
                    if (res_valid_reg) begin
                        hi_next = res_hi_reg;
                        lo_next = res_lo_reg;
                    end
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy  = (state_reg == ST_RUN);
    assign stall = busy | (start & is_long_op(op));
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule
